// File: rtl/game_pkg.sv
// Shared types, constants and scoring helpers for the two-player card game.
package game_pkg;

    localparam int W_CARD    = 5;
    localparam int W_SCORE   = 6;
    localparam int W_COUNT   = 3;
    localparam int TARGET    = 21;
    localparam int MAX_CARDS = 5;
    localparam int CARD_ACE  = 1;
    localparam int CARD_MAX  = 10;
    localparam int ACE_BONUS = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_TIE  = 2'b11
    } winner_t;

    // An ace counts high only while that keeps the hand at or under the target.
    function automatic logic [W_SCORE-1:0] best_score(input logic [W_SCORE-1:0] raw,
                                                      input logic ace);
        logic [W_SCORE-1:0] high;
        high = raw + W_SCORE'(ACE_BONUS);
        if (ace && (high <= W_SCORE'(TARGET))) begin
            best_score = high;
        end else begin
            best_score = raw;
        end
    endfunction

    function automatic logic card_ok(input logic [W_CARD-1:0] value);
        card_ok = (value >= W_CARD'(CARD_ACE)) && (value <= W_CARD'(CARD_MAX));
    endfunction

endpackage

// File: rtl/hand_acc.sv
// One player's hand: raw sum, ace flag and card count, with the best score
// and end-of-turn condition for both the current and the post-card hand.
module hand_acc
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               add,
    input  logic [W_CARD-1:0]  value,
    output logic [W_SCORE-1:0] score,
    output logic               bust,
    output logic [W_SCORE-1:0] score_next,
    output logic               bust_next,
    output logic               over_next
);

    logic [W_SCORE-1:0] raw;
    logic [W_SCORE-1:0] raw_nx;
    logic               ace;
    logic               ace_nx;
    logic [W_COUNT-1:0] count;
    logic [W_COUNT-1:0] count_nx;

    // Hand update for this cycle's accepted card or clear.
    always_comb begin
        raw_nx   = raw;
        ace_nx   = ace;
        count_nx = count;
        if (clear) begin
            raw_nx   = '0;
            ace_nx   = 1'b0;
            count_nx = '0;
        end else if (add) begin
            raw_nx   = raw + W_SCORE'(value);
            ace_nx   = ace | (value == W_CARD'(CARD_ACE));
            count_nx = count + W_COUNT'(1);
        end else begin
            raw_nx   = raw;
        end
    end

    // Hand state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw   <= '0;
            ace   <= 1'b0;
            count <= '0;
        end else begin
            raw   <= raw_nx;
            ace   <= ace_nx;
            count <= count_nx;
        end
    end

    // The look-ahead view lets the turn end on the same edge that takes the final card.
    assign score      = best_score(raw, ace);
    assign bust       = score > W_SCORE'(TARGET);
    assign score_next = best_score(raw_nx, ace_nx);
    assign bust_next  = score_next > W_SCORE'(TARGET);
    assign over_next  = bust_next || (score_next == W_SCORE'(TARGET))
                        || (count_nx >= W_COUNT'(MAX_CARDS));

endmodule

// File: rtl/hand_scorer.sv
// Two-player score keeper: turn FSM, card accept/reject decode and winner compare.
module hand_scorer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               deal_valid,
    input  logic               whose,
    input  logic [W_CARD-1:0]  card_value1,
    input  logic [W_CARD-1:0]  card_value2,
    input  logic               stand1,
    input  logic               stand2,
    output logic               turn,
    output logic [W_SCORE-1:0] score1,
    output logic [W_SCORE-1:0] score2,
    output logic               bust1,
    output logic               bust2,
    output logic               card_err,
    output logic               done,
    output logic [1:0]         winner
);

    state_t             state;
    state_t             next_state;
    winner_t            winner_r;
    winner_t            win_calc;
    logic               card_err_r;
    logic               add1;
    logic               add2;
    logic               err;
    logic [W_SCORE-1:0] score1_next;
    logic [W_SCORE-1:0] score2_next;
    logic               bust1_next;
    logic               bust2_next;
    logic               over1_next;
    logic               over2_next;

    hand_acc u_hand1 (
        .clk        (clk),
        .rst        (rst),
        .clear      (new_game),
        .add        (add1),
        .value      (card_value1),
        .score      (score1),
        .bust       (bust1),
        .score_next (score1_next),
        .bust_next  (bust1_next),
        .over_next  (over1_next)
    );

    hand_acc u_hand2 (
        .clk        (clk),
        .rst        (rst),
        .clear      (new_game),
        .add        (add2),
        .value      (card_value2),
        .score      (score2),
        .bust       (bust2),
        .score_next (score2_next),
        .bust_next  (bust2_next),
        .over_next  (over2_next)
    );

    // Card accept/reject decode; new_game swallows any card in the same cycle.
    always_comb begin
        add1 = 1'b0;
        add2 = 1'b0;
        err  = 1'b0;
        if (!new_game && deal_valid) begin
            if ((state == S_P1) && !whose && card_ok(card_value1)) begin
                add1 = 1'b1;
            end else if ((state == S_P2) && whose && card_ok(card_value2)) begin
                add2 = 1'b1;
            end else begin
                err = 1'b1;
            end
        end else begin
            err = 1'b0;
        end
    end

    // Turn sequencing.
    always_comb begin
        next_state = state;
        if (new_game) begin
            next_state = S_P1;
        end else begin
            case (state)
                S_IDLE:  next_state = S_IDLE;
                S_P1:    if (stand1 || over1_next) next_state = S_P2;
                         else                      next_state = S_P1;
                S_P2:    if (stand2 || over2_next) next_state = S_DONE;
                         else                      next_state = S_P2;
                S_DONE:  next_state = S_DONE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Winner from the final hands, including a card landing on the closing edge.
    always_comb begin
        win_calc = WIN_TIE;
        if (bust1_next && bust2_next) begin
            win_calc = WIN_TIE;
        end else if (bust1_next) begin
            win_calc = WIN_P2;
        end else if (bust2_next) begin
            win_calc = WIN_P1;
        end else if (score1_next > score2_next) begin
            win_calc = WIN_P1;
        end else if (score1_next < score2_next) begin
            win_calc = WIN_P2;
        end else begin
            win_calc = WIN_TIE;
        end
    end

    // State, winner and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            winner_r   <= WIN_NONE;
            card_err_r <= 1'b0;
        end else begin
            state      <= next_state;
            card_err_r <= err;
            if (new_game) begin
                winner_r <= WIN_NONE;
            end else if ((state == S_P2) && (next_state == S_DONE)) begin
                winner_r <= win_calc;
            end else begin
                winner_r <= winner_r;
            end
        end
    end

    assign turn     = (state == S_P2);
    assign done     = (state == S_DONE);
    assign winner   = winner_r;
    assign card_err = card_err_r;

endmodule

// File: doc/hand_scorer.md
Name: hand_scorer

Overview:
- Two-player score keeper and turn sequencer for the card game, directly downstream of the card demux.
- Consumes the per-player card values the demux produces, accumulates each hand with ace-high/low resolution, and detects bust.
- Sequences the turn from player 1 to player 2, then reports the winner.
- Drives `turn`, which feeds the demux `whose` select, closing the loop.

Parameters:
W_CARD, 5, card value width (matches demux outputs)
W_SCORE, 6, score width; holds raw sum up to MAX_CARDS*10
TARGET, 21, bust threshold (score > TARGET is bust)
MAX_CARDS, 5, hand size limit; reaching it forces stand

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
new_game  in  1  1-cycle pulse: clear hands, start player 1 turn
deal_valid  in  1  1-cycle pulse: a card is present on the demux output selected by whose
whose  in  1  demux select accompanying deal_valid (0 = player 1, 1 = player 2)
card_value1  in  W_CARD  card routed to player 1 (1 = ace, 2..10 face value)
card_value2  in  W_CARD  card routed to player 2
stand1  in  1  player 1 stand pulse
stand2  in  1  player 2 stand pulse
turn  out  1  player expected to receive the next card; drives demux whose
score1  out  W_SCORE  player 1 best score
score2  out  W_SCORE  player 2 best score
bust1  out  1  player 1 score > TARGET
bust2  out  1  player 2 score > TARGET
card_err  out  1  1-cycle pulse: card ignored
done  out  1  game finished; winner valid
winner  out  2  00 = none/not done, 01 = player 1, 10 = player 2, 11 = tie

Behaviour:
- Reset (async, active-high): state S_IDLE; all sums, ace flags and card counters cleared; every output 0.
- FSM states:
  - S_IDLE: waits for new_game, then goes to S_P1.
  - S_P1: player 1 turn; turn=0.
  - S_P2: player 2 turn; turn=1.
  - S_DONE: terminal; holds until new_game.
- new_game in any state:
  - Clears raw sums, ace flags, counters, bust, done and winner.
  - Enters S_P1 the next cycle.
  - Has priority over every other input in the same cycle.
- Card acceptance: deal_valid=1, whose equals the current turn player, and the selected card value is in 1..10.
  - On accept: raw sum += value, card count += 1, ace flag set if value==1.
  - Registered: score and bust reflect the card on the cycle after deal_valid is sampled.
- Card rejection: a card in S_IDLE/S_DONE, a card with whose != turn, or a value of 0 or >10.
  - Rejected cards are not added; card_err pulses for 1 cycle.
- Best score: raw+10 if ace flag set and raw+10 <= TARGET, else raw. Combinational from registered raw sum and ace flag. No saturation needed, since max raw = 50 < 64.
- bust = best score > TARGET.
- Leaving S_P1 for S_P2 (exactly one transition) happens on any of:
  - stand1,
  - player 1 bust,
  - player 1 best score == TARGET,
  - card count reaches MAX_CARDS.
- Leaving S_P2 for S_DONE uses the same conditions for player 2, with stand2.
- Same-cycle card and stand: the card is applied, and the stand takes effect in that same transition.
- A stand pulse for the player not on turn is ignored, with no card_err.
- S_DONE: done=1; winner is registered on entry and held.
  - Both bust → 11.
  - One bust → the other player wins.
  - Otherwise the higher score wins; equal scores → 11.
- turn reflects the state register: 0 in S_IDLE/S_P1/S_DONE, 1 in S_P2.

Decomposition:
- Shared package game_pkg:
  - State encoding: S_IDLE, S_P1, S_P2, S_DONE.
  - Winner codes: WIN_NONE, WIN_P1, WIN_P2, WIN_TIE.
  - Constants: CARD_ACE=1, CARD_MAX=10, ACE_BONUS=10.
- Sub-module hand_acc, instantiated twice: per-player raw sum, ace flag, card counter, best-score and bust logic.
- Top level holds the FSM, the accept/reject decode and the winner compare.

Test Plan:
- Reset: rst=1 mid-game → next clock all outputs 0; after rst=0, idle until new_game.
- P1 cards 10, ace, then stand1; P2 cards 9, 8, then stand2 → score1=21, which auto-advances after the ace, so stand1 is ignored; score2=17; winner=01; done=1.
- P1 cards 10, 5, 9 → bust1=1, turn=1 next cycle; P2 card 2 then stand2 → winner=10.
- Soft ace: P1 cards ace, 6 → score1=17; add 10 → score1=17 (ace now low, raw=17).
- Errors:
  - deal_valid with whose=1 during S_P1 → card_err pulse, score1 unchanged.
  - card value 12 → card_err.
  - deal_valid in S_IDLE → card_err.
- Five cards 2,2,2,2,2 to P1 → score1=10, forced advance to S_P2.
- Tie at 18/18 → winner=11.
- new_game together with deal_valid in S_DONE → hands cleared, that card not counted.
